mult_div_unit: RTL and testbench

Multiply/divide unit for the 5-stage MIPS pipeline, sitting in the Execute stage beside the ALU. It answers the `MDU` class flag raised by the Decode stage. It performs the latency-modelled mult/multu/div/divu operations and the mthi/mtlo writes, and holds the HI/LO registers. It also returns the stall request the hazard unit uses to freeze F/D while an MDU instruction would collide with a busy unit.

---
 rtl/mult_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the Execute stage: latency-modelled mult/div, mthi/mtlo,
// mfhi/mflo read port and the F/D stall request for colliding MDU instructions.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_mdu_op,
    input  logic [1:0]  E_mdu_read,
    input  logic [31:0] E_rs_data,
    input  logic [31:0] E_rt_data,
    input  logic        D_MDU,
    output logic [31:0] E_mdu_out,
    output logic        busy,
    output logic        D_mdu_stall
);

    // state | meaning
    // IDLE  | counter 0, busy 0; accepts ops 1-4 and mthi/mtlo
    // RUN   | counter >= 1, busy 1; shadow result commits on the 1->0 edge
    typedef enum logic {IDLE, RUN} state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_t;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   hi;
    logic [31:0]   lo;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          commit;

    mdu_op_t op;
    logic    start;
    logic    is_mt;

    assign op    = mdu_op_t'(E_mdu_op);
    assign start = !busy && (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU);
    assign is_mt = (op == OP_MTHI) || (op == OP_MTLO);

    // Product: low 64 bits of the product of properly extended operands
    logic signed [63:0] a_s;
    logic signed [63:0] b_s;
    logic        [63:0] prod_s;
    logic        [63:0] prod_u;

    assign a_s    = {{32{E_rs_data[31]}}, E_rs_data};
    assign b_s    = {{32{E_rt_data[31]}}, E_rt_data};
    assign prod_s = a_s * b_s;
    assign prod_u = {32'b0, E_rs_data} * {32'b0, E_rt_data};

    // One shared unsigned divider; signed div runs on magnitudes and fixes signs afterwards,
    // which also makes 0x80000000 / -1 fall out naturally as 0x80000000 r 0.
    logic        rs_neg;
    logic        rt_neg;
    logic        div_zero;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    assign rs_neg   = E_rs_data[31];
    assign rt_neg   = E_rt_data[31];
    assign div_zero = (E_rt_data == 32'd0);
    assign rs_mag   = rs_neg ? -E_rs_data : E_rs_data;
    assign rt_mag   = rt_neg ? -E_rt_data : E_rt_data;
    assign dvd      = (op == OP_DIV) ? rs_mag : E_rs_data;
    assign dvs      = div_zero ? 32'd1 : ((op == OP_DIV) ? rt_mag : E_rt_data);
    assign quo      = dvd / dvs;
    assign rem      = dvd % dvs;
    assign quo_s    = (rs_neg ^ rt_neg) ? -quo : quo;
    assign rem_s    = rs_neg ? -rem : rem;

    logic [31:0]   nxt_hi;
    logic [31:0]   nxt_lo;
    logic [CW-1:0] nxt_load;
    logic          nxt_commit;

    always_comb begin
        nxt_hi     = 32'd0;
        nxt_lo     = 32'd0;
        nxt_load   = MULT_LOAD;
        nxt_commit = 1'b1;
        case (op)
            OP_MULT:  {nxt_hi, nxt_lo} = prod_s;
            OP_MULTU: {nxt_hi, nxt_lo} = prod_u;
            OP_DIV: begin
                nxt_hi     = rem_s;
                nxt_lo     = quo_s;
                nxt_load   = DIV_LOAD;
                nxt_commit = !div_zero;
            end
            OP_DIVU: begin
                nxt_hi     = rem;
                nxt_lo     = quo;
                nxt_load   = DIV_LOAD;
                nxt_commit = !div_zero;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            commit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        res_hi <= nxt_hi;
                        res_lo <= nxt_lo;
                        commit <= nxt_commit;
                        cnt    <= nxt_load;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else if (op == OP_MTHI) begin
                        hi <= E_rs_data;
                    end else if (op == OP_MTLO) begin
                        lo <= E_rs_data;
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (commit) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (E_mdu_read)
            2'd1:    E_mdu_out = hi;
            2'd2:    E_mdu_out = lo;
            default: E_mdu_out = 32'd0;
        endcase
    end

    assign D_mdu_stall = D_MDU && (start || busy);

    mt_while_busy: assert property (@(posedge clk) disable iff (reset) !(busy && is_mt));

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random op stream checked against an
// arithmetic HI/LO model; latency and stall are checked cycle by cycle per operation.
module tb_mult_div_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        reset;
    logic [2:0]  E_mdu_op;
    logic [1:0]  E_mdu_read;
    logic [31:0] E_rs_data;
    logic [31:0] E_rt_data;
    logic        D_MDU;
    logic [31:0] E_mdu_out;
    logic        busy;
    logic        D_mdu_stall;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk),
        .reset(reset),
        .E_mdu_op(E_mdu_op),
        .E_mdu_read(E_mdu_read),
        .E_rs_data(E_rs_data),
        .E_rt_data(E_rt_data),
        .D_MDU(D_MDU),
        .E_mdu_out(E_mdu_out),
        .busy(busy),
        .D_mdu_stall(D_mdu_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result of an MDU arithmetic op, from plain 64-bit arithmetic.
    task automatic model_result(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                output logic [31:0] hi_o, output logic [31:0] lo_o);
        longint      sa, sb, q, r;
        logic [63:0] p, qq, rr;
        hi_o = m_hi;
        lo_o = m_lo;
        case (op)
            3'd1: begin
                sa = longint'($signed(rs));
                sb = longint'($signed(rt));
                p  = sa * sb;
                hi_o = p[63:32];
                lo_o = p[31:0];
            end
            3'd2: begin
                p = {32'b0, rs} * {32'b0, rt};
                hi_o = p[63:32];
                lo_o = p[31:0];
            end
            3'd3: if (rt != 0) begin
                sa = longint'($signed(rs));
                sb = longint'($signed(rt));
                q  = sa / sb;
                r  = sa % sb;
                qq = q;
                rr = r;
                lo_o = qq[31:0];
                hi_o = rr[31:0];
            end
            3'd4: if (rt != 0) begin
                lo_o = rs / rt;
                hi_o = rs % rt;
            end
            default: ;
        endcase
    endtask

    // Called in the first half of a cycle; leaves time in the same cycle.
    task automatic read_check(input string tag);
        E_mdu_read = 2'd1; #1 check({tag, "_hi"}, E_mdu_out, m_hi);
        E_mdu_read = 2'd2; #1 check({tag, "_lo"}, E_mdu_out, m_lo);
        E_mdu_read = 2'd3; #1 check({tag, "_rd3"}, E_mdu_out, 32'd0);
        E_mdu_read = 2'd0; #1 check({tag, "_rd0"}, E_mdu_out, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic dmdu);
        logic [31:0] eh, el;
        int n;
        n = (op <= 3'd2) ? MULT_CYCLES : DIV_CYCLES;
        model_result(op, rs, rt, eh, el);
        E_mdu_op = op; E_rs_data = rs; E_rt_data = rt; D_MDU = dmdu; E_mdu_read = 2'd1;
        #1;
        check({tag, "_stall_T"}, 32'(D_mdu_stall), 32'(dmdu));
        check({tag, "_busy_T"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        E_mdu_op = 3'd0;
        for (int i = 1; i <= n; i++) begin
            check({tag, "_busy_run"}, 32'(busy), 32'd1);
            check({tag, "_stall_run"}, 32'(D_mdu_stall), 32'(dmdu));
            check({tag, "_nobypass"}, E_mdu_out, m_hi);
            @(posedge clk); #1;
        end
        m_hi = eh;
        m_lo = el;
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_stall_done"}, 32'(D_mdu_stall), 32'd0);
        read_check(tag);
    endtask

    task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] val);
        E_mdu_op = op; E_rs_data = val; E_rt_data = $urandom; D_MDU = 1'b1;
        #1 check({tag, "_stall"}, 32'(D_mdu_stall), 32'd0);
        @(posedge clk); #1;
        E_mdu_op = 3'd0;
        if (op == 3'd5) m_hi = val; else m_lo = val;
        read_check(tag);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1; E_mdu_op = 3'd0; E_mdu_read = 2'd0;
        E_rs_data = 32'd0; E_rt_data = 32'd0; D_MDU = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(D_mdu_stall), 32'd0);
        read_check("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("divu", 3'd4, 32'd7, 32'd2, 1'b1);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        run_mt("mthi", 3'd5, 32'h11);
        run_mt("mtlo", 3'd6, 32'h22);
        run_op("divu0", 3'd4, 32'd5, 32'd0, 1'b1);
        run_mt("mtlo2", 3'd6, 32'hABCD);

        E_mdu_op = 3'd7; E_rs_data = 32'h1234; E_rt_data = 32'd3; D_MDU = 1'b1;
        #1 check("rsvd_stall", 32'(D_mdu_stall), 32'd0);
        @(posedge clk); #1;
        E_mdu_op = 3'd0;
        check("rsvd_busy", 32'(busy), 32'd0);
        read_check("rsvd");

        // Reset during the third busy cycle of a div
        E_mdu_op = 3'd3; E_rs_data = 32'd100; E_rt_data = 32'd7;
        @(posedge clk); #1;
        E_mdu_op = 3'd0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_stall", 32'(D_mdu_stall), 32'd0);
        read_check("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        run_op("post_rst_mult", 3'd1, 32'd3, 32'd4, 1'b1);
        repeat (DIV_CYCLES + 2) begin @(posedge clk); #1; end
        read_check("post_rst_hold");

        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            if (rop <= 3'd4) run_op("rnd", rop, ra, rb, 1'($urandom_range(0, 1)));
            else run_mt("rnd_mt", rop, ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
